// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

  typedef logic [31:0] word;

  localparam int LOADER_COUNT_BITS = 16;

  typedef enum logic [2:0] {
    HDR_LO = 3'd0,
    HDR_HI = 3'd1,
    DATA   = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } loader_state_t;

  // States in which the loader is willing to take a stream byte.
  function automatic logic accepts_bytes(input loader_state_t s);
    return (s == HDR_LO) || (s == HDR_HI) || (s == DATA) || (s == CHECK);
  endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
interface instruction_loader_if #(
  parameter int MEM_BITS = 12
);
  logic                byte_valid;
  logic [7:0]          byte_data;
  logic                byte_ready;
  logic                wr_en;
  logic [MEM_BITS-3:0] wr_addr;
  logic [31:0]         wr_data;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instruction_loader_byte_assembler.sv
// Packs accepted bytes LSB-first into 32-bit words; word_valid pulses one
// cycle after the fourth byte, and word_out holds until the next word.
module byte_assembler
  import loader_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       byte_accept,
  input  logic [7:0] byte_data,
  output logic       word_done,
  output logic       word_valid,
  output word        word_out
);

  logic [1:0]  lane_reg;
  logic [23:0] shift_reg;
  word         word_reg;
  logic        valid_reg;

  // Combinational: this accept completes a word (used for address bookkeeping).
  assign word_done  = byte_accept && (lane_reg == 2'd3);
  assign word_valid = valid_reg;
  assign word_out   = word_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      lane_reg  <= 2'd0;
      shift_reg <= 24'd0;
      word_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= word_done && !clear;
      if (clear) begin
        lane_reg  <= 2'd0;
        shift_reg <= 24'd0;
      end else if (byte_accept) begin
        lane_reg <= lane_reg + 2'd1;
        if (word_done) begin
          word_reg <= {byte_data, shift_reg};
        end else begin
          shift_reg <= {byte_data, shift_reg[23:8]};
        end
      end
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Boot loader: header-framed byte stream -> instruction memory words, CPU held
// until done. Optional trailing XOR checksum: INSTRUCTION_LOADER_CHECKSUM_EN.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int MEM_BITS = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  restart,
  instruction_loader_if.slave   bus,
  output logic                  load_done,
  output logic                  load_error,
  output logic                  hold_cpu
);

  localparam int WORD_BITS = MEM_BITS - 2;
  localparam logic [LOADER_COUNT_BITS:0] MAX_WORDS =
    (LOADER_COUNT_BITS + 1)'(1) << WORD_BITS;

  loader_state_t                 state_reg, state_next;
  logic                          byte_ready_reg;
  logic [7:0]                    lo_reg;
  logic [LOADER_COUNT_BITS-1:0]  count_reg;
  logic [LOADER_COUNT_BITS-1:0]  word_cnt_reg;
  logic [WORD_BITS-1:0]          wr_addr_reg;

  logic                          accept;
  logic                          rearm;
  logic                          data_accept;
  logic                          last_word;
  logic [LOADER_COUNT_BITS-1:0]  hdr_count;
  logic                          word_done;
  logic                          word_valid;
  word                           word_q;

  assign accept      = bus.byte_valid && byte_ready_reg;
  assign rearm       = restart && ((state_reg == DONE) || (state_reg == ERROR));
  assign data_accept = accept && (state_reg == DATA);
  assign hdr_count   = {bus.byte_data, lo_reg};
  assign last_word   = word_done && (word_cnt_reg == count_reg - 16'd1);

  byte_assembler u_assembler (
    .clock       (clock),
    .reset       (reset),
    .clear       (rearm),
    .byte_accept (data_accept),
    .byte_data   (bus.byte_data),
    .word_done   (word_done),
    .word_valid  (word_valid),
    .word_out    (word_q)
  );

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [7:0] xor_reg;

  // Running XOR of data bytes only; restarted by each new header.
  always_ff @(posedge clock) begin
    if (!reset) begin
      xor_reg <= 8'd0;
    end else if (rearm || (accept && (state_reg == HDR_LO))) begin
      xor_reg <= 8'd0;
    end else if (data_accept) begin
      xor_reg <= xor_reg ^ bus.byte_data;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HDR_LO: if (accept) state_next = HDR_HI;
      HDR_HI: begin
        if (accept) begin
          if (hdr_count == '0) begin
            state_next = DONE;
          end else if ({1'b0, hdr_count} > MAX_WORDS) begin
            state_next = ERROR;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        if (last_word) state_next = CHECK;
`else
        // Leave only after the final strobe, when the counter has caught up.
        if (word_valid && (word_cnt_reg == count_reg)) state_next = DONE;
`endif
      end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) state_next = (bus.byte_data == xor_reg) ? DONE : ERROR;
      end
`endif
      DONE, ERROR: if (restart) state_next = HDR_LO;
      default: state_next = HDR_LO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg      <= HDR_LO;
      byte_ready_reg <= 1'b0;
      lo_reg         <= 8'd0;
      count_reg      <= '0;
      word_cnt_reg   <= '0;
      wr_addr_reg    <= '0;
    end else begin
      state_reg <= state_next;
      // Drop ready during the final write strobe so nothing spills past the image.
      byte_ready_reg <= accepts_bytes(state_next) && !((state_next == DATA) && last_word);
      if (accept && (state_reg == HDR_LO)) lo_reg <= bus.byte_data;
      if (rearm) begin
        count_reg <= '0;
      end else if (accept && (state_reg == HDR_HI)) begin
        count_reg <= hdr_count;
      end
      if (rearm) begin
        word_cnt_reg <= '0;
      end else if (word_done) begin
        word_cnt_reg <= word_cnt_reg + 16'd1;
      end
      if (word_done) wr_addr_reg <= word_cnt_reg[WORD_BITS-1:0];
    end
  end

  assign bus.byte_ready = byte_ready_reg;
  assign bus.wr_en      = word_valid;
  assign bus.wr_data    = word_q;
  assign bus.wr_addr    = wr_addr_reg;

  assign load_done  = (state_reg == DONE);
  assign load_error = (state_reg == ERROR);
  assign hold_cpu   = !load_done;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench: vector table, hand sequences and random frames against a frame-level model.
module tb_instruction_loader;
  import loader_pkg::*;

  localparam int MEM_BITS = 12;
  localparam int WORDS    = 1 << (MEM_BITS - 2);

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic restart = 1'b0;
  logic load_done, load_error, hold_cpu;

  instruction_loader_if #(.MEM_BITS(MEM_BITS)) bus ();

  instruction_loader #(.MEM_BITS(MEM_BITS)) dut (
    .clock      (clock),
    .reset      (reset),
    .restart    (restart),
    .bus        (bus),
    .load_done  (load_done),
    .load_error (load_error),
    .hold_cpu   (hold_cpu)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } wr_t;

  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic [7:0] frame_q[$];
  bit         exp_done;
  bit         exp_error;

  typedef struct {
    logic [7:0]  b[12];
    int          len;
    bit          done;
    bit          err;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t vt[3];

  always @(negedge clock) begin
    if (bus.wr_en) got_q.push_back('{addr: int'(bus.wr_addr), data: bus.wr_data});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Frame-level reference: header count, little-endian words, optional XOR trailer.
  task automatic model();
    int cnt;
    logic [7:0] x;
    exp_q.delete();
    cnt = int'(frame_q[0]) | (int'(frame_q[1]) << 8);
    exp_done = 1'b0;
    exp_error = 1'b0;
    x = 8'd0;
    if (cnt == 0) begin
      exp_done = 1'b1;
    end else if (cnt > WORDS) begin
      exp_error = 1'b1;
    end else begin
      for (int i = 0; i < cnt; i++) begin
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < 4; k++) begin
          w = w | (32'(frame_q[2 + 4*i + k]) << (8*k));
          x = x ^ frame_q[2 + 4*i + k];
        end
        exp_q.push_back('{addr: i, data: w});
      end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      exp_done  = (frame_q[2 + 4*cnt] == x);
      exp_error = !exp_done;
`else
      exp_done = 1'b1;
`endif
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, input string tag);
    int tries;
    bit rdy;
    tries = 0;
    forever begin
      @(negedge clock);
      if (gaps && ($urandom_range(0, 1) == 0)) begin
        bus.byte_valid = 1'b0;
      end else begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
      end
      rdy = bus.byte_ready && bus.byte_valid;
      @(posedge clock);
      #1 bus.byte_valid = 1'b0;
      if (rdy) break;
      tries++;
      if (tries > 64) begin
        check({tag, " accept timeout"}, 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic send_frame(input bit gaps, input string tag);
    int n;
    got_q.delete();
    foreach (frame_q[i]) send_byte(frame_q[i], gaps, tag);
    n = 0;
    while (!(load_done || load_error) && (n < 40)) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
  endtask

  task automatic check_status(input string tag, input bit done, input bit err);
    check({tag, " load_done"}, 32'(load_done), 32'(done));
    check({tag, " load_error"}, 32'(load_error), 32'(err));
    check({tag, " hold_cpu"}, 32'(hold_cpu), 32'(!done));
    check({tag, " byte_ready"}, 32'(bus.byte_ready), 32'd0);
  endtask

  task automatic check_model(input string tag);
    check({tag, " nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s addr%0d", tag, i), got_q[i].addr, exp_q[i].addr);
      check($sformatf("%s data%0d", tag, i), got_q[i].data, exp_q[i].data);
    end
    check_status(tag, exp_done, exp_error);
    $display("frame %s: words=%0d done=%0d error=%0d", tag, got_q.size(), load_done, load_error);
  endtask

  task automatic do_restart(input string tag);
    @(negedge clock);
    restart = 1'b1;
    @(posedge clock);
    #1 restart = 1'b0;
    @(negedge clock);
    check({tag, " restart done"}, 32'(load_done), 32'd0);
    check({tag, " restart error"}, 32'(load_error), 32'd0);
    check({tag, " restart ready"}, 32'(bus.byte_ready), 32'd1);
  endtask

  task automatic random_frame(input int cnt);
    logic [7:0] x;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'(cnt));
    frame_q.push_back(8'(cnt >> 8));
    x = 8'd0;
    if (cnt > 0 && cnt <= WORDS) begin
      for (int i = 0; i < 4*cnt; i++) begin
        b = 8'($urandom);
        x = x ^ b;
        frame_q.push_back(b);
      end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      frame_q.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'h5a) : x);
`endif
    end
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;

    // Reset held three cycles.
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("rst byte_ready", 32'(bus.byte_ready), 32'd0);
      check("rst wr_en", 32'(bus.wr_en), 32'd0);
      check("rst wr_addr", 32'(bus.wr_addr), 32'd0);
      check("rst wr_data", bus.wr_data, 32'd0);
      check("rst load_done", 32'(load_done), 32'd0);
      check("rst load_error", 32'(load_error), 32'd0);
      check("rst hold_cpu", 32'(hold_cpu), 32'd1);
    end
    reset = 1'b1;

    vt[0].b = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90, 8'h00};
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    vt[0].len = 11;
`else
    vt[0].len = 10;
`endif
    vt[0].done = 1'b1; vt[0].err = 1'b0; vt[0].nw = 2;
    vt[0].w0 = 32'h0000_0013; vt[0].w1 = 32'h0010_0093;
    vt[1].b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[1].len = 2; vt[1].done = 1'b1; vt[1].err = 1'b0; vt[1].nw = 0;
    vt[1].w0 = 32'd0; vt[1].w1 = 32'd0;
    vt[2].b = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[2].len = 2; vt[2].done = 1'b0; vt[2].err = 1'b1; vt[2].nw = 0;
    vt[2].w0 = 32'd0; vt[2].w1 = 32'd0;

    for (int i = 0; i < 3; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      frame_q.delete();
      for (int k = 0; k < vt[i].len; k++) frame_q.push_back(vt[i].b[k]);
      send_frame(1'b0, tag);
      check({tag, " nwrites"}, 32'(got_q.size()), 32'(vt[i].nw));
      if (vt[i].nw > 0 && got_q.size() > 0) begin
        check({tag, " addr0"}, got_q[0].addr, 32'd0);
        check({tag, " data0"}, got_q[0].data, vt[i].w0);
      end
      if (vt[i].nw > 1 && got_q.size() > 1) begin
        check({tag, " addr1"}, got_q[1].addr, 32'd1);
        check({tag, " data1"}, got_q[1].data, vt[i].w1);
      end
      check_status(tag, vt[i].done, vt[i].err);
      $display("frame %s: words=%0d done=%0d error=%0d", tag, got_q.size(), load_done, load_error);
      do_restart(tag);
    end

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    for (int v = 0; v < 2; v++) begin
      string tag;
      tag = $sformatf("cksum%0d", v);
      frame_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'(v)};
      send_frame(1'b0, tag);
      check({tag, " nwrites"}, 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) begin
        check({tag, " addr0"}, got_q[0].addr, 32'd0);
        check({tag, " data0"}, got_q[0].data, 32'hDDCC_BBAA);
      end
      check_status(tag, (v == 0), (v == 1));
      $display("frame %s: words=%0d done=%0d error=%0d", tag, got_q.size(), load_done, load_error);
      do_restart(tag);
    end
`endif

    // Same 4-word image gapless then with random valid gaps.
    random_frame(4);
    model();
    send_frame(1'b0, "img4 nogap");
    check_model("img4 nogap");
    do_restart("img4 nogap");
    send_frame(1'b1, "img4 gap");
    check_model("img4 gap");
    do_restart("img4 gap");

    for (int r = 0; r < 8; r++) begin
      int cnt;
      string tag;
      tag = $sformatf("rnd%0d", r);
      cnt = (r == 7) ? int'($urandom_range(WORDS + 1, 65535)) : int'($urandom_range(0, 6));
      if (r == 6) cnt = WORDS;
      random_frame(cnt);
      model();
      send_frame(r[0], tag);
      check_model(tag);
      do_restart(tag);
    end

    // Reset pulse mid-load after two words, then a fresh frame from address 0.
    begin
      int n;
      random_frame(4);
      got_q.delete();
      for (int i = 0; i < 10; i++) send_byte(frame_q[i], 1'b1, "abort");
      n = 0;
      while (got_q.size() < 2 && n < 20) begin
        @(negedge clock);
        n++;
      end
      check("abort words before reset", 32'(got_q.size()), 32'd2);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      check("abort byte_ready", 32'(bus.byte_ready), 32'd0);
      check("abort wr_en", 32'(bus.wr_en), 32'd0);
      check("abort wr_addr", 32'(bus.wr_addr), 32'd0);
      check("abort wr_data", bus.wr_data, 32'd0);
      check("abort load_done", 32'(load_done), 32'd0);
      check("abort hold_cpu", 32'(hold_cpu), 32'd1);
      $display("abort: reset applied after %0d words", 2);
      random_frame(3);
      model();
      send_frame(1'b1, "fresh");
      check_model("fresh");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Write-side counterpart of the fetch-stage instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Drives the instruction memory write port (word address, data, enable) and holds the CPU in reset until the program image is fully written.
- Sits between the host/serial front end and instruction memory; active only at boot or after restart.

Parameters:
- MEM_BITS, 12, byte-address width of instruction memory (size = 2**MEM_BITS bytes, 2**(MEM_BITS-2) words).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-low (reset==0 resets block)
- restart  input  1  re-arm loader; honoured only in DONE or ERROR
- byte_valid  input  1  source presents byte_data
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts byte this cycle
- wr_en  output  1  one-cycle write strobe to instruction memory
- wr_addr  output  MEM_BITS-2  word address
- wr_data  output  32  assembled instruction word
- load_done  output  1  image fully written
- load_error  output  1  length overflow (or checksum mismatch)
- hold_cpu  output  1  equals !load_done; gates pipeline reset

Behaviour:
- Reset (reset==0 at posedge): state HDR_LO; byte_ready=0 that cycle; wr_en=0, wr_addr=0, wr_data=0, load_done=0, load_error=0, hold_cpu=1; byte lane counter=0; word counter=0.
- A byte is accepted on a clock edge where byte_valid && byte_ready. byte_ready is a registered function of state: 1 in HDR_LO, HDR_HI, DATA, CHECK; 0 elsewhere. byte_data is ignored when not accepted.
- Frame format: count[7:0], count[15:8], then 4*count data bytes, LSB first per word.
- HDR_LO -> HDR_HI on accept (latch low byte).
- HDR_HI on accept:
  - count==0 -> DONE.
  - count > 2**(MEM_BITS-2) -> ERROR.
  - else -> DATA.
- DATA:
  - Each accepted byte is shifted into lane 0..3.
  - On the 4th lane, the next cycle drives wr_en=1 for exactly one cycle, with wr_data = assembled word and wr_addr = word counter.
  - The word counter then increments.
  - byte_ready stays 1; back-to-back bytes are allowed every cycle.
- After the final word's write strobe: -> DONE (or CHECK if CHECKSUM_EN).
- DONE: load_done=1, hold_cpu=0, byte_ready=0.
- ERROR: load_error=1, load_done=0, hold_cpu=1, byte_ready=0. No writes occur after entry.
- restart=1 in DONE/ERROR: -> HDR_LO next cycle; clears load_done, load_error and counters. restart is ignored in other states.
- Reset asserted mid-load aborts immediately. Words already written are not undone, and a fresh frame is required.
- wr_addr wraps never: the count check guarantees word counter < 2**(MEM_BITS-2).
- wr_data and wr_addr hold their last values when wr_en=0.

Optional Feature:
- Macro: INSTRUCTION_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte, state CHECK expects one byte equal to the XOR of all data bytes; header bytes are excluded.
  - Match -> DONE; mismatch -> ERROR.
  - The running XOR resets with the header.
  - Words are still written during DATA; the checksum gates only load_done.
- Undefined:
  - No CHECK state and no XOR register; the last write goes to DONE.

Decomposition:
- Package loader_pkg:
  - loader_state_t enum (HDR_LO, HDR_HI, DATA, CHECK, DONE, ERROR).
  - Constant LOADER_COUNT_BITS=16.
  - Reuses `word` from common definitions.
- Sub-module byte_assembler:
  - 2-bit lane counter plus 32-bit shift register.
  - Outputs word_valid pulse and assembled word.
  - Cleared on reset or restart.
- Top-level owns the FSM, word counter, checksum and outputs.

Test Plan:
- Reset held low 3 cycles -> all outputs at reset values, hold_cpu=1, byte_ready=0 during reset.
- Stream 02 00 13 00 00 00 93 00 10 00, one byte per cycle:
  - wr_en pulses twice: addr 0 data 0x00000013; addr 1 data 0x00100093.
  - load_done=1 after the second write; hold_cpu=0.
- Header 00 00 -> DONE directly, no wr_en pulses.
- With MEM_BITS=12, header 01 04 (1025 words) -> ERROR; load_error=1; byte_ready=0; no writes; restart -> HDR_LO.
- Random byte_valid gaps (50% duty) with a 4-word image -> identical writes/addresses to the gapless case; reset pulse after word 2 -> back to HDR_LO, counters cleared.
- CHECKSUM_EN, 1 word AA BB CC DD:
  - Checksum byte 0x00 -> DONE.
  - Checksum byte 0x01 -> ERROR, with the word still written at addr 0.
